// File: rtl/accum_pkg.sv
// Shared types for the accumulator write scheduler.
package accum_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} accum_wr_state_e;

   typedef enum logic {ACC_OVERWRITE, ACC_ACCUMULATE} accum_mode_e;

endpackage

// File: rtl/accum_wr_sched_if.sv
// Tile handshake and per-column write bus between the tile sequencer
// (master) and the accumulator write scheduler (slave).
interface accum_wr_sched_if #(
   parameter int SYS_COL   = 16,
   parameter int ACCUM_ROW = 256,
   parameter int ROW_CNT_W = 16
);
   localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);

   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ROW_CNT_W-1:0]  num_rows;
   logic                  acc_mode;
   logic                  valid_in;
   logic                  busy;
   logic                  done;
   logic [SYS_COL-1:0]    wr_en_out;
   logic [SYS_COL-1:0]    wr_acc_out;
   logic [ADDR_WIDTH-1:0] wr_addr_out [0:SYS_COL-1];

   modport master (
      output start, base_addr, num_rows, acc_mode, valid_in,
      input  busy, done, wr_en_out, wr_acc_out, wr_addr_out
   );

   modport slave (
      input  start, base_addr, num_rows, acc_mode, valid_in,
      output busy, done, wr_en_out, wr_acc_out, wr_addr_out
   );

endinterface

// File: rtl/accum_skew_pipe.sv
// Delay line producing SYS_COL taps of one word: tap i is the input
// delayed by i cycles, tap 0 is a straight pass-through.
module accum_skew_pipe #(
   parameter int WIDTH   = 1,
   parameter int SYS_COL = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tap [0:SYS_COL-1]
);

   // A single shared shift chain: stage i already holds din delayed i
   // cycles, which is exactly what each tap of the triangle needs.
   logic [WIDTH-1:0] stage_q [1:SYS_COL-1];

   // Shift the word one column per cycle; reset clears every stage.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 1; i < SYS_COL; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[1] <= din;
         for (int unsigned i = 2; i < SYS_COL; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   // Present the pass-through and delayed taps.
   always_comb begin
      tap[0] = din;
      for (int unsigned i = 1; i < SYS_COL; i++) begin
         tap[i] = stage_q[i];
      end
   end

endmodule

// File: rtl/accum_wr_sched.sv
// Accumulator write scheduler: walks a tile of rows from a base address
// (wrapping at ACCUM_ROW) and skews enable/mode/address across the columns
// to follow the diagonal output wavefront of the systolic array.
module accum_wr_sched
   import accum_pkg::*;
#(
   parameter int SYS_COL   = 16,
   parameter int ACCUM_ROW = 256,
   parameter int ROW_CNT_W = 16
) (
   input logic              clk,
   input logic              rstn,
   accum_wr_sched_if.slave  bus
);

   localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);
   localparam int DRAIN_W    = (SYS_COL > 2) ? $clog2(SYS_COL) : 1;
   localparam int WORD_W     = ADDR_WIDTH + 2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(ACCUM_ROW - 1);
   localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(SYS_COL - 2);

   accum_wr_state_e       state_q;
   accum_mode_e           mode_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ROW_CNT_W-1:0]  rows_q;
   logic [ROW_CNT_W-1:0]  row_cnt_q;
   logic [DRAIN_W-1:0]    drain_cnt_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  accept;
   logic [WORD_W-1:0]     col0_word;
   logic [WORD_W-1:0]     tap_word [0:SYS_COL-1];

   assign accept = (state_q == RUN) && bus.valid_in;

   // Column-0 write word {en, acc, addr}; held at zero outside RUN.
   always_comb begin
      col0_word = '0;
      if (state_q == RUN) begin
         col0_word = {bus.valid_in, (mode_q == ACC_ACCUMULATE), addr_q};
      end
   end

   // Tile sequencing FSM with registered busy/done.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         mode_q      <= ACC_OVERWRITE;
         addr_q      <= '0;
         rows_q      <= '0;
         row_cnt_q   <= '0;
         drain_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  addr_q    <= bus.base_addr;
                  rows_q    <= bus.num_rows;
                  mode_q    <= accum_mode_e'(bus.acc_mode);
                  row_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  if (bus.num_rows == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  addr_q    <= (addr_q == LAST_ROW) ? '0 : addr_q + ADDR_WIDTH'(1);
                  row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
                  if (row_cnt_q == rows_q - ROW_CNT_W'(1)) begin
                     state_q     <= DRAIN;
                     drain_cnt_q <= DRAIN_LOAD;
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   accum_skew_pipe #(
      .WIDTH   (WORD_W),
      .SYS_COL (SYS_COL)
   ) u_skew (
      .clk  (clk),
      .rstn (rstn),
      .din  (col0_word),
      .tap  (tap_word)
   );

   // Split each skewed tap back into the per-column bus fields.
   always_comb begin
      for (int unsigned i = 0; i < SYS_COL; i++) begin
         bus.wr_en_out[i]   = tap_word[i][WORD_W-1];
         bus.wr_acc_out[i]  = tap_word[i][WORD_W-2];
         bus.wr_addr_out[i] = tap_word[i][ADDR_WIDTH-1:0];
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
